// File: rtl/dimc_mac_array_p.sv
// Parametrised DIMC macro: masked kernel memory, feature buffer and a LAT-deep dot-product pipeline.
// Define DIMC_ACC_EN to add the ACCE port and the chained result accumulator.
module dimc_mac_array_p #(
  parameter int COL_W = 256,
  parameter int NSEC  = 4,
  parameter int ROWS  = 32,
  parameter int PS_W  = 24,
  parameter int LAT   = 4
) (
  input  logic                                 RCK,
  input  logic                                 RESETn,
  input  logic                                 WCSN,
  input  logic                                 WEN,
  input  logic [$clog2(ROWS)+$clog2(NSEC)-1:0] WA,
  input  logic [COL_W-1:0]                     D,
  input  logic [COL_W-1:0]                     M,
  input  logic                                 RCSN,
  input  logic [$clog2(ROWS)+$clog2(NSEC)-1:0] RA,
  output logic [COL_W-1:0]                     Q,
  input  logic                                 FCSN,
  input  logic [$clog2(NSEC)-1:0]              FA,
  input  logic [COL_W-1:0]                     FD,
  input  logic                                 COMPE,
  input  logic [1:0]                           MODE,
  input  logic [PS_W-1:0]                      ADDIN,
  input  logic [PS_W-1:0]                      THR,
`ifdef DIMC_ACC_EN
  input  logic                                 ACCE,
`endif
  output logic                                 READYN,
  output logic [PS_W-1:0]                      PSOUT,
  output logic [2:0]                           RES_OUT,
  output logic                                 SOUT
);

  localparam int SW  = $clog2(NSEC);
  localparam int RW  = $clog2(ROWS);
  localparam int G   = COL_W / 4;
  localparam int SSW = $clog2(G * 225 + 1);
  localparam int TW  = SSW + SW;
  localparam int EW  = ((TW > PS_W) ? TW : PS_W) + 1;
  localparam int DLY = LAT - 4;

  typedef struct packed {
    logic                   acce;
    logic [1:0]             mode;
    logic [PS_W-1:0]        add;
    logic [PS_W-1:0]        thr;
    logic [NSEC*SSW-1:0]    sums;
  } fin_t;

  logic [COL_W-1:0] mem_q  [ROWS*NSEC];
  logic [COL_W-1:0] feat_q [NSEC];
  logic [COL_W-1:0] q_q;

  logic             issue;
  logic             issue_acce;
  logic [RW-1:0]    ra_row;

  assign issue  = !RCSN && COMPE;
  assign ra_row = RA[RW+SW-1:SW];
`ifdef DIMC_ACC_EN
  assign issue_acce = ACCE;
`else
  assign issue_acce = 1'b0;
`endif

  always_ff @(posedge RCK) begin
    if (!WCSN && !WEN) mem_q[WA] <= (D & M) | (mem_q[WA] & ~M);
  end

  always_ff @(posedge RCK) begin
    if (!RESETn) begin
      q_q <= '0;
      for (int s = 0; s < NSEC; s++) feat_q[s] <= '0;
    end else begin
      if (!RCSN && !COMPE) q_q <= mem_q[RA];
      if (!FCSN) feat_q[FA] <= FD;
    end
  end

  // Stage 1: operands sampled before any same-edge write lands.
  logic             s1_vld_q, s1_acce_q;
  logic [1:0]       s1_mode_q;
  logic [PS_W-1:0]  s1_add_q, s1_thr_q;
  logic [COL_W-1:0] s1_k_q [NSEC];
  logic [COL_W-1:0] s1_f_q [NSEC];

  always_ff @(posedge RCK) begin
    if (!RESETn) begin
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= issue;
      if (issue) begin
        s1_mode_q <= MODE;
        s1_add_q  <= ADDIN;
        s1_thr_q  <= THR;
        s1_acce_q <= issue_acce;
        for (int s = 0; s < NSEC; s++) begin
          s1_k_q[s] <= mem_q[{ra_row, s[SW-1:0]}];
          s1_f_q[s] <= feat_q[s];
        end
      end
    end
  end

  // Each nibble contributes one lane value covering every precision.
  function automatic logic [7:0] lane(input logic [1:0] mode, input logic [3:0] k, input logic [3:0] f);
    logic [3:0] b;
    b = (mode == 2'b11) ? ~(k ^ f) : (k & f);
    case (mode)
      2'b01:   lane = 8'(k[1:0]) * 8'(f[1:0]) + 8'(k[3:2]) * 8'(f[3:2]);
      2'b10:   lane = 8'(k) * 8'(f);
      default: lane = 8'(b[0]) + 8'(b[1]) + 8'(b[2]) + 8'(b[3]);
    endcase
  endfunction

  logic            s2_vld_q, s2_acce_q;
  logic [1:0]      s2_mode_q;
  logic [PS_W-1:0] s2_add_q, s2_thr_q;
  logic [7:0]      s2_grp_q [NSEC][G];

  always_ff @(posedge RCK) begin
    if (!RESETn) begin
      s2_vld_q <= 1'b0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_mode_q <= s1_mode_q;
        s2_add_q  <= s1_add_q;
        s2_thr_q  <= s1_thr_q;
        s2_acce_q <= s1_acce_q;
        for (int s = 0; s < NSEC; s++)
          for (int g = 0; g < G; g++)
            s2_grp_q[s][g] <= lane(s1_mode_q, s1_k_q[s][4*g +: 4], s1_f_q[s][4*g +: 4]);
      end
    end
  end

  logic [NSEC*SSW-1:0] sec_sum_d;

  always_comb begin
    sec_sum_d = '0;
    for (int s = 0; s < NSEC; s++) begin
      for (int g = 0; g < G; g++)
        sec_sum_d[s*SSW +: SSW] = sec_sum_d[s*SSW +: SSW] + SSW'(s2_grp_q[s][g]);
    end
  end

  logic s3_vld_q;
  fin_t s3_q;

  always_ff @(posedge RCK) begin
    if (!RESETn) begin
      s3_vld_q <= 1'b0;
    end else begin
      s3_vld_q <= s2_vld_q;
      if (s2_vld_q) s3_q <= '{acce: s2_acce_q, mode: s2_mode_q, add: s2_add_q, thr: s2_thr_q, sums: sec_sum_d};
    end
  end

  logic fin_vld;
  fin_t fin;

  generate
    if (DLY == 0) begin : g_nodly
      assign fin_vld = s3_vld_q;
      assign fin     = s3_q;
    end else begin : g_dly
      fin_t             dly_q [DLY];
      logic [DLY-1:0]   dvld_q;
      always_ff @(posedge RCK) begin
        if (!RESETn) begin
          dvld_q <= '0;
        end else begin
          dvld_q[0] <= s3_vld_q;
          dly_q[0]  <= s3_q;
          for (int i = 1; i < DLY; i++) begin
            dvld_q[i] <= dvld_q[i-1];
            dly_q[i]  <= dly_q[i-1];
          end
        end
      end
      assign fin_vld = dvld_q[DLY-1];
      assign fin     = dly_q[DLY-1];
    end
  endgenerate

  logic [PS_W-1:0] acc_w, addend, psout_d;
  logic [EW-1:0]   total;
  logic            sat_d;

  assign addend = fin.acce ? acc_w : fin.add;

  always_comb begin
    total = EW'(addend);
    for (int s = 0; s < NSEC; s++) total = total + EW'(fin.sums[s*SSW +: SSW]);
    sat_d   = |total[EW-1:PS_W];
    psout_d = sat_d ? '1 : total[PS_W-1:0];
  end

`ifdef DIMC_ACC_EN
  logic [PS_W-1:0] acc_q;
  always_ff @(posedge RCK) begin
    if (!RESETn)      acc_q <= '0;
    else if (fin_vld) acc_q <= psout_d;
  end
  assign acc_w = acc_q;
`else
  assign acc_w = '0;
`endif

  logic            readyn_q, sout_q;
  logic [PS_W-1:0] psout_q;
  logic [2:0]      res_q;

  // Results hold between retirements; READYN pulses once per retired op.
  always_ff @(posedge RCK) begin
    if (!RESETn) begin
      readyn_q <= 1'b1;
      psout_q  <= '0;
      res_q    <= '0;
      sout_q   <= 1'b0;
    end else begin
      readyn_q <= !fin_vld;
      if (fin_vld) begin
        psout_q <= psout_d;
        res_q   <= {fin.mode, sat_d};
        sout_q  <= (psout_d >= fin.thr);
      end
    end
  end

  assign Q       = q_q;
  assign READYN  = readyn_q;
  assign PSOUT   = psout_q;
  assign RES_OUT = res_q;
  assign SOUT    = sout_q;

endmodule

// File: tb/tb_dimc_mac_array_p.sv
// Scoreboard bench for dimc_mac_array_p: reference model queues expected results at issue,
// a monitor retires them whenever READYN is low.
module tb_dimc_mac_array_p;
  localparam int COL_W = 256;
  localparam int NSEC  = 4;
  localparam int ROWS  = 32;
  localparam int PS_W  = 24;
  localparam int LAT   = 4;
  localparam int AW    = 7;

  typedef struct {
    logic [PS_W-1:0] ps;
    logic [2:0]      res;
    logic            sout;
    int              issueEdge;
  } exp_t;

  logic RCK = 1'b0;
  logic RESETn, WCSN, WEN, RCSN, FCSN, COMPE, READYN, SOUT;
  logic [AW-1:0] WA, RA;
  logic [COL_W-1:0] D, M, FD, Q;
  logic [1:0] FA, MODE;
  logic [PS_W-1:0] ADDIN, THR, PSOUT;
  logic [2:0] RES_OUT;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t expq[$];

  logic [COL_W-1:0] kmem [ROWS*NSEC];
  logic [COL_W-1:0] fmem [NSEC];
  logic [COL_W-1:0] qModel;

  dimc_mac_array_p #(.COL_W(COL_W), .NSEC(NSEC), .ROWS(ROWS), .PS_W(PS_W), .LAT(LAT)) dut (
    .RCK(RCK), .RESETn(RESETn), .WCSN(WCSN), .WEN(WEN), .WA(WA), .D(D), .M(M),
    .RCSN(RCSN), .RA(RA), .Q(Q), .FCSN(FCSN), .FA(FA), .FD(FD), .COMPE(COMPE),
    .MODE(MODE), .ADDIN(ADDIN), .THR(THR),
`ifdef DIMC_ACC_EN
    .ACCE(1'b0),
`endif
    .READYN(READYN), .PSOUT(PSOUT), .RES_OUT(RES_OUT), .SOUT(SOUT)
  );

  // Free-running clock and an edge counter used to check result latency.
  always #5 RCK = ~RCK;
  always @(posedge RCK) cyc = cyc + 1;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [COL_W-1:0] act, input logic [COL_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [COL_W-1:0] rand256();
    logic [COL_W-1:0] v;
    for (int i = 0; i < COL_W / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Dot product straight from the element definitions of each precision.
  function automatic exp_t refOp(input int row, input logic [1:0] mode, input logic [PS_W-1:0] add,
                                 input logic [PS_W-1:0] thr);
    exp_t e;
    longint sum, total;
    logic [COL_W-1:0] k, f, ks, fs;
    int w;
    sum = 0;
    w = (mode == 2'b00) ? 1 : (mode == 2'b01) ? 2 : 4;
    for (int s = 0; s < NSEC; s++) begin
      k = kmem[row*NSEC + s];
      f = fmem[s];
      if (mode == 2'b11) begin
        for (int b = 0; b < COL_W; b++) if (k[b] == f[b]) sum++;
      end else begin
        for (int el = 0; el < COL_W / w; el++) begin
          ks = k >> (el * w);
          fs = f >> (el * w);
          sum += (longint'(ks[3:0]) & ((1 << w) - 1)) * (longint'(fs[3:0]) & ((1 << w) - 1));
        end
      end
    end
    total = sum + longint'(add);
    e.res[0] = (total > 64'hFFFFFF);
    e.ps = e.res[0] ? 24'hFFFFFF : total[PS_W-1:0];
    e.res[2:1] = mode;
    e.sout = (e.ps >= thr);
    e.issueEdge = 0;
    return e;
  endfunction

  task automatic idle();
    RESETn = 1'b1; WCSN = 1'b1; WEN = 1'b1; RCSN = 1'b1; COMPE = 1'b0; FCSN = 1'b1;
  endtask

  task automatic setWrite(input int a, input logic [COL_W-1:0] d, input logic [COL_W-1:0] m);
    WCSN = 1'b0; WEN = 1'b0; WA = AW'(a); D = d; M = m;
  endtask

  task automatic setFeat(input int a, input logic [COL_W-1:0] d);
    FCSN = 1'b0; FA = 2'(a); FD = d;
  endtask

  task automatic setIssue(input int row, input logic [1:0] mode, input logic [PS_W-1:0] add,
                          input logic [PS_W-1:0] thr);
    RCSN = 1'b0; COMPE = 1'b1; RA = AW'(row * NSEC + int'($urandom_range(0, NSEC - 1)));
    MODE = mode; ADDIN = add; THR = thr;
  endtask

  task automatic setRead(input int a);
    RCSN = 1'b0; COMPE = 1'b0; RA = AW'(a);
  endtask

  // One clock: update the model with read-before-write order, step past the edge, check Q.
  task automatic applyStimulus();
    exp_t e;
    logic chkQ;
    chkQ = !RCSN;
    if (!RCSN && COMPE) begin
      e = refOp(int'(RA[AW-1:2]), MODE, ADDIN, THR);
      e.issueEdge = cyc + 1;
      expq.push_back(e);
    end
    if (!RCSN && !COMPE) qModel = kmem[RA];
    if (!WCSN && !WEN) kmem[WA] = (D & M) | (kmem[WA] & ~M);
    if (!FCSN) fmem[FA] = FD;
    if (!RESETn) begin
      for (int s = 0; s < NSEC; s++) fmem[s] = '0;
      qModel = '0;
      expq.delete();
    end
    @(negedge RCK);
    if (chkQ) checkOutput("Q", Q, qModel);
    idle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 20) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain", COL_W'(expq.size()), '0);
  endtask

  // Monitor: every READYN-low cycle retires the oldest expected result.
  always @(negedge RCK) begin : monitor
    exp_t e;
    if (READYN === 1'b0) begin
      if (expq.size() == 0) begin
        checkOutput("spuriousReady", COL_W'(READYN), COL_W'(1));
      end else begin
        e = expq.pop_front();
        checkOutput("PSOUT", COL_W'(PSOUT), COL_W'(e.ps));
        checkOutput("RES_OUT", COL_W'(RES_OUT), COL_W'(e.res));
        checkOutput("SOUT", COL_W'(SOUT), COL_W'(e.sout));
        checkOutput("latency", COL_W'(cyc), COL_W'(e.issueEdge + LAT - 1));
      end
    end
  end

  // Directed scenarios first, then a randomized mix, then a reset with ops in flight.
  initial begin
    idle();
    WA = '0; RA = '0; D = '0; M = '0; FA = '0; FD = '0; MODE = '0; ADDIN = '0; THR = '0;
    qModel = '0;
    for (int s = 0; s < NSEC; s++) fmem[s] = '0;
    repeat (2) begin
      RESETn = 1'b0;
      applyStimulus();
    end
    checkOutput("rstREADYN", COL_W'(READYN), COL_W'(1));
    checkOutput("rstPSOUT", COL_W'(PSOUT), '0);
    checkOutput("rstRES_OUT", COL_W'(RES_OUT), '0);
    checkOutput("rstSOUT", COL_W'(SOUT), '0);
    checkOutput("rstQ", Q, '0);

    for (int a = 0; a < ROWS * NSEC; a++) begin
      setWrite(a, rand256(), '1);
      if (a < NSEC) setFeat(a, rand256());
      applyStimulus();
    end

    setWrite(0, {32{8'hA5}}, '1);
    applyStimulus();
    setWrite(0, '0, 256'h0F);
    applyStimulus();
    setRead(0);
    applyStimulus();

    for (int r = 0; r < 5; r++)
      for (int s = 0; s < NSEC; s++) begin
        setWrite(r * NSEC + s, '1, '1);
        applyStimulus();
      end
    for (int s = 0; s < NSEC; s++) begin
      setFeat(s, '1);
      applyStimulus();
    end
    setIssue(0, 2'b00, 24'd0, 24'd1024);
    applyStimulus();
    drain();

    setWrite(5 * NSEC, 256'h3, '1);
    setFeat(0, 256'h5);
    applyStimulus();
    for (int s = 1; s < NSEC; s++) begin
      setWrite(5 * NSEC + s, '0, '1);
      setFeat(s, '0);
      applyStimulus();
    end
    setIssue(5, 2'b10, 24'd10, 24'd25);
    applyStimulus();
    setIssue(5, 2'b11, 24'd10, 24'd2000);
    applyStimulus();
    drain();

    for (int s = 0; s < NSEC; s++) begin
      setFeat(s, '1);
      applyStimulus();
    end
    for (int r = 0; r < 5; r++) begin
      setIssue(r, (r % 2 == 0) ? 2'b00 : 2'b10, PS_W'($urandom_range(0, 500)), PS_W'($urandom_range(0, 60000)));
      applyStimulus();
    end
    drain();

    setIssue(1, 2'b10, 24'(2 ** 24 - 100), 24'hFFFFFF);
    applyStimulus();
    drain();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 3) setWrite(int'($urandom_range(0, ROWS * NSEC - 1)), rand256(), rand256());
      if ($urandom_range(0, 3) == 0) setFeat(int'($urandom_range(0, NSEC - 1)), rand256());
      if ($urandom_range(0, 3) != 3)
        setIssue(int'($urandom_range(0, ROWS - 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0) ? PS_W'(24'hFFFFFF - $urandom_range(0, 20000)) : PS_W'($urandom_range(0, 1000)),
                 PS_W'($urandom_range(0, 16000)));
      else
        setRead(int'($urandom_range(0, ROWS * NSEC - 1)));
      applyStimulus();
    end
    drain();

    setIssue(0, 2'b00, 24'd3, 24'd0);
    applyStimulus();
    setIssue(1, 2'b10, 24'd4, 24'd0);
    applyStimulus();
    RESETn = 1'b0;
    applyStimulus();
    checkOutput("midRstREADYN", COL_W'(READYN), COL_W'(1));
    checkOutput("midRstPSOUT", COL_W'(PSOUT), '0);
    checkOutput("midRstRES_OUT", COL_W'(RES_OUT), '0);
    checkOutput("midRstSOUT", COL_W'(SOUT), '0);
    repeat (6) applyStimulus();
    for (int r = 0; r < 5; r++) begin
      setRead(r * NSEC + (r % NSEC));
      applyStimulus();
    end
    setIssue(0, 2'b00, 24'd7, 24'd7);
    applyStimulus();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
